inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 134 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch front end. Drives the instruction ROM (byte address plus
//   active-low read strobe) and captures the big-endian word returned in the
//   same cycle. Each fetched word is buffered with its PC in a small FIFO, and
//   the issue stage drains that FIFO through a valid/ready handshake. A branch
//   redirect flushes the FIFO and restarts fetch. A fetched halt opcode
//   (bits [31:26] all ones) stops fetch.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   RESET_PC   fetch PC after reset
//   MEM_BYTES  ROM size in bytes; last fetchable word starts at MEM_BYTES-4
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   nrd, addr     ROM read strobe (active low) and byte address (= fetch PC)
//   dataIn        ROM word, meaningful only while nrd = 0
//   instValid     head of FIFO holds an instruction
//   instOut       head instruction word (0 when empty)
//   instPC        head instruction PC (0 when empty)
//   issueReady    issue stage takes the head this cycle
//   redirect      flush and restart fetch at redirectPC (word aligned)
//   halted        a halt word was fetched; fetch is stopped
module inst_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned MEM_BYTES = 100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        nrd,
    output logic [31:0] addr,
    input  logic [31:0] dataIn,
    output logic        instValid,
    output logic [31:0] instOut,
    output logic [31:0] instPC,
    input  logic        issueReady,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        halted
);

    localparam int unsigned   PtrW      = $clog2(DEPTH);
    localparam logic [31:0]   LastAddr  = 32'(MEM_BYTES - 4);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            halted_q, halted_d;

    logic [31:0]     word_q [DEPTH];
    logic [31:0]     epc_q  [DEPTH];

    logic            pop;
    logic            fetch_en;
    logic            is_halt;

    // Low address bits of a redirect target are dropped on purpose.
    logic [1:0]      unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirectPC[1:0];

    assign instValid = (count_q != '0);
    assign instOut   = instValid ? word_q[rd_ptr_q] : 32'h0;
    assign instPC    = instValid ? epc_q[rd_ptr_q]  : 32'h0;
    assign halted    = halted_q;
    assign addr      = pc_q;

    assign pop      = instValid & issueReady;
    // A full FIFO can still fetch when the head leaves in the same cycle.
    assign fetch_en = !rst && !redirect && !halted_q && (pc_q <= LastAddr) &&
                      ((count_q < CountFull) || pop);
    assign nrd      = ~fetch_en;
    assign is_halt  = (dataIn[31:26] == 6'b111111);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (redirect) begin
            // Any same-cycle pop is simply discarded with the rest of the FIFO.
            pc_d     = {redirectPC[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (fetch_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (is_halt) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({fetch_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            word_q[wr_ptr_q] <= dataIn;
            epc_q[wr_ptr_q]  <= pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        nrd;
    logic [31:0] addr;
    logic [31:0] dataIn;
    logic        instValid;
    logic [31:0] instOut;
    logic [31:0] instPC;
    logic        issueReady;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        halted;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] rom [32];

    always #5 clk = ~clk;

    // ROM drives the bus only while the strobe is active.
    always_comb begin
        dataIn = 32'hzzzz_zzzz;
        if (!nrd) dataIn = rom[addr[6:2]];
    end

    inst_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .MEM_BYTES(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nrd       (nrd),
        .addr      (addr),
        .dataIn    (dataIn),
        .instValid (instValid),
        .instOut   (instOut),
        .instPC    (instPC),
        .issueReady(issueReady),
        .redirect  (redirect),
        .redirectPC(redirectPC),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issueReady = 1'b0;
        redirect = 1'b0;
        redirectPC = 32'h0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + i;
        rom[0] = 32'h2001_0005;
        rom[1] = 32'h2002_0003;
        rom[2] = 32'h0022_1820;
    endtask

    initial begin
        load_rom();
        rst = 1'b1;
        issueReady = 1'b0;
        redirect = 1'b0;
        redirectPC = 32'h0;
        #1;

        // Reset state, sampled while rst is still high after an edge.
        tick();
        check("rst_nrd", 32'(nrd), 32'd1);
        check("rst_valid", 32'(instValid), 32'd0);
        check("rst_instOut", instOut, 32'h0);
        check("rst_instPC", instPC, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);

        // Streaming with issueReady held high.
        rst = 1'b0;
        issueReady = 1'b1;
        #1;
        check("s1_nrd", 32'(nrd), 32'd0);
        check("s1_addr", addr, 32'h0);
        tick();
        check("s2_valid", 32'(instValid), 32'd1);
        check("s2_inst", instOut, 32'h2001_0005);
        check("s2_pc", instPC, 32'h0);
        check("s2_addr", addr, 32'h4);
        tick();
        check("s3_inst", instOut, 32'h2002_0003);
        check("s3_pc", instPC, 32'h4);
        tick();
        check("s4_inst", instOut, 32'h0022_1820);
        check("s4_pc", instPC, 32'h8);

        // Full FIFO: four fetches with no issue.
        do_reset();
        repeat (4) tick();
        check("full_nrd", 32'(nrd), 32'd1);
        check("full_addr", addr, 32'h10);
        check("full_head", instPC, 32'h0);
        issueReady = 1'b1;
        #1;
        check("full_pop_nrd", 32'(nrd), 32'd0);
        tick();
        issueReady = 1'b0;
        #1;
        check("full_after_pc", instPC, 32'h4);
        check("full_after_inst", instOut, 32'h2002_0003);
        check("full_after_addr", addr, 32'h14);
        check("full_still_full", 32'(nrd), 32'd1);

        // Halt word at address 8.
        rom[2] = 32'hFC00_0000;
        do_reset();
        repeat (3) tick();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_addr", addr, 32'h8);
        check("halt_nrd", 32'(nrd), 32'd1);
        tick();
        check("halt_hold_addr", addr, 32'h8);
        check("halt_hold_nrd", 32'(nrd), 32'd1);
        issueReady = 1'b1;
        tick();
        check("halt_pop1", instPC, 32'h4);
        tick();
        check("halt_issue_pc", instPC, 32'h8);
        check("halt_issue_inst", instOut, 32'hFC00_0000);
        tick();
        check("halt_drained", 32'(instValid), 32'd0);
        check("halt_nrd_late", 32'(nrd), 32'd1);
        issueReady = 1'b0;
        redirect = 1'b1;
        redirectPC = 32'h0;
        tick();
        redirect = 1'b0;
        #1;
        check("halt_redir_clr", 32'(halted), 32'd0);
        check("halt_redir_nrd", 32'(nrd), 32'd0);
        load_rom();

        // Redirect with a full FIFO and a simultaneous pop.
        do_reset();
        repeat (4) tick();
        redirect = 1'b1;
        redirectPC = 32'h0000_000E;
        issueReady = 1'b1;
        #1;
        check("redir_nrd_same", 32'(nrd), 32'd1);
        tick();
        redirect = 1'b0;
        issueReady = 1'b0;
        #1;
        check("redir_valid", 32'(instValid), 32'd0);
        check("redir_halted", 32'(halted), 32'd0);
        check("redir_addr", addr, 32'hC);
        check("redir_nrd", 32'(nrd), 32'd0);
        tick();
        check("redir_first_pc", instPC, 32'hC);
        check("redir_first_inst", instOut, 32'h1000_0003);
        check("redir_first_valid", 32'(instValid), 32'd1);

        // Range stall at MEM_BYTES = 100.
        do_reset();
        issueReady = 1'b1;
        repeat (25) tick();
        check("range_addr", addr, 32'd100);
        check("range_nrd", 32'(nrd), 32'd1);
        check("range_halted", 32'(halted), 32'd0);
        check("range_last_pc", instPC, 32'd96);
        tick();
        check("range_empty", 32'(instValid), 32'd0);
        check("range_hold", addr, 32'd100);
        redirect = 1'b1;
        redirectPC = 32'h0;
        tick();
        redirect = 1'b0;
        #1;
        check("range_resume_nrd", 32'(nrd), 32'd0);
        check("range_resume_addr", addr, 32'h0);

        // Reset in the middle of a stream with three entries queued.
        do_reset();
        repeat (3) tick();
        check("mid_pre_valid", 32'(instValid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_nrd", 32'(nrd), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_valid", 32'(instValid), 32'd0);
        check("mid_inst", instOut, 32'h0);
        check("mid_addr", addr, 32'h0);
        check("mid_nrd", 32'(nrd), 32'd0);
        tick();
        check("mid_refetch_pc", instPC, 32'h0);
        check("mid_refetch_inst", instOut, 32'h2001_0005);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
